// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative multiply/divide unit with its own HI/LO registers.
// Handles MULT/MULTU/DIV/DIVU in multiple cycles and MTHI/MTLO in a single edge.
// Multiply is shift-add and divide is restoring, one bit per cycle each, on
// operand magnitudes. Signs are applied in the FIX state.
//
// Optional feature macro: MD_FAST_MUL_EN. When defined, a multiply skips RUN and
// FIX forms the full product with '*'.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    asynchronous reset, active low
//   i_start  command valid, sampled only in IDLE
//   i_func   001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//   i_a      rs operand (multiplicand, dividend or MT source)
//   i_b      rt operand (multiplier or divisor)
//   i_flush  EX flush; aborts the current or requested operation
//   o_busy   high whenever the state is not IDLE
//   o_done   one-cycle pulse when a MUL/DIV result lands in HI/LO
//   o_hi     HI register
//   o_lo     LO register
module md_iter_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic [2:0]      i_func,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic            i_flush,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [2:0] F_MULT  = 3'b001;
   localparam logic [2:0] F_MULTU = 3'b010;
   localparam logic [2:0] F_DIV   = 3'b011;
   localparam logic [2:0] F_DIVU  = 3'b100;
   localparam logic [2:0] F_MTHI  = 3'b101;
   localparam logic [2:0] F_MTLO  = 3'b110;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   // Multiply: {partial product high, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits shifting into quotient}.
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_opnd;     // multiplicand or divisor magnitude
   logic              r_is_div;
   logic              r_neg_p;
   logic              r_neg_q;
   logic              r_neg_r;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic              r_done;

   logic [1:0]        w_state_nxt;
   logic              w_accept;
   logic              w_is_mul;
   logic              w_is_div;
   logic              w_signed;
   logic              w_sa;
   logic              w_sb;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic [XLEN:0]     w_msum;
   logic [2*XLEN-1:0] w_mul_nxt;
   logic [XLEN:0]     w_rem_sh;
   logic [XLEN:0]     w_div_ext;
   logic [XLEN:0]     w_diff;
   logic              w_ge;
   logic [2*XLEN-1:0] w_div_nxt;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0]   w_res_hi;
   logic [XLEN-1:0]   w_res_lo;

   assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;
   assign w_is_mul = (i_func == F_MULT) || (i_func == F_MULTU);
   assign w_is_div = (i_func == F_DIV) || (i_func == F_DIVU);
   assign w_signed = (i_func == F_MULT) || (i_func == F_DIV);
   assign w_sa     = w_signed & i_a[XLEN-1];
   assign w_sb     = w_signed & i_b[XLEN-1];
   assign w_a_mag  = w_sa ? -i_a : i_a;
   assign w_b_mag  = w_sb ? -i_b : i_b;

   // Shift-add step: conditionally add multiplicand to the high half, shift right.
   assign w_msum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_nxt = {w_msum, r_acc[XLEN-1:1]};

   // Restoring step: shift the next dividend bit into the remainder, try subtract.
   assign w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
   assign w_div_ext = {1'b0, r_opnd};
   assign w_ge      = (w_rem_sh >= w_div_ext);
   assign w_diff    = w_rem_sh - w_div_ext;
   assign w_div_nxt = w_ge ? {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                           : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

`ifdef MD_FAST_MUL_EN
   assign w_prod = {{XLEN{1'b0}}, r_opnd} * {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
`else
   assign w_prod = r_acc;
`endif
   assign w_prod_s = r_neg_p ? -w_prod : w_prod;

   always_comb begin
      w_res_hi = w_prod_s[2*XLEN-1:XLEN];
      w_res_lo = w_prod_s[XLEN-1:0];
      if (r_is_div) begin
         w_res_hi = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
         w_res_lo = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_is_mul) begin
`ifdef MD_FAST_MUL_EN
               w_state_nxt = S_FIX;
`else
               w_state_nxt = S_RUN;
`endif
            end else if (w_accept && w_is_div) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (i_flush) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CNT_W'(XLEN - 1)) begin
               w_state_nxt = S_FIX;
            end
         end
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_neg_p  <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_is_mul || w_is_div) begin
                     r_is_div <= w_is_div;
                     r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
                     r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                     r_cnt    <= '0;
                     r_neg_p  <= w_sa ^ w_sb;
                     // Divide by zero keeps an all-ones quotient regardless of sign.
                     r_neg_q  <= (w_sa ^ w_sb) & (|i_b);
                     r_neg_r  <= w_sa;
                  end else if (i_func == F_MTHI) begin
                     r_hi <= i_a;
                  end else if (i_func == F_MTLO) begin
                     r_lo <= i_a;
                  end
               end
            end
            S_RUN: begin
               if (!i_flush) begin
                  r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_FIX: begin
               if (!i_flush) begin
                  r_hi   <= w_res_hi;
                  r_lo   <= w_res_lo;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy = (r_state != S_IDLE);
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: tb/tb_md_iter_unit.sv
// Scoreboard bench for md_iter_unit (XLEN=32): stimulus pushes expected {hi,lo}
// for each MUL/DIV, a monitor pops and compares on every done pulse.
module tb_md_iter_unit;

   localparam int X = 32;
`ifdef MD_FAST_MUL_EN
   localparam int MUL_BUSY = 1;
`else
   localparam int MUL_BUSY = X + 1;
`endif
   localparam int DIV_BUSY = X + 1;

   localparam logic [2:0] F_MULT  = 3'b001;
   localparam logic [2:0] F_MULTU = 3'b010;
   localparam logic [2:0] F_DIV   = 3'b011;
   localparam logic [2:0] F_DIVU  = 3'b100;
   localparam logic [2:0] F_MTHI  = 3'b101;
   localparam logic [2:0] F_MTLO  = 3'b110;

   logic         clk;
   logic         rst;
   logic         start;
   logic [2:0]   func;
   logic [X-1:0] a;
   logic [X-1:0] b;
   logic         flush;
   logic         busy;
   logic         done;
   logic [X-1:0] hi;
   logic [X-1:0] lo;

   int n_tests;
   int n_fail;
   int n_pushed;
   int n_done;
   logic [2*X-1:0] sb_q[$];
   logic [X-1:0]   exp_hi;
   logic [X-1:0]   exp_lo;

   md_iter_unit #(.XLEN(X)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_start(start),
      .i_func (func),
      .i_a    (a),
      .i_b    (b),
      .i_flush(flush),
      .o_busy (busy),
      .o_done (done),
      .o_hi   (hi),
      .o_lo   (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [X-1:0] act, input logic [X-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (rst && done) begin
         n_done++;
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: got hi=0x%08h lo=0x%08h expected no done", hi, lo);
         end else begin
            logic [2*X-1:0] e;
            e = sb_q.pop_front();
            if ({hi, lo} !== e) begin
               n_fail++;
               $display("FAIL result: got hi=0x%08h lo=0x%08h expected hi=0x%08h lo=0x%08h",
                        hi, lo, e[2*X-1:X], e[X-1:0]);
            end
         end
      end
   end

   task automatic issue(input logic [2:0] f, input logic [X-1:0] va, input logic [X-1:0] vb,
                        input logic fl);
      start = 1'b1;
      func  = f;
      a     = va;
      b     = vb;
      flush = fl;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
   endtask

   // Run one MUL/DIV, optionally pulsing a stray MTHI start while busy.
   task automatic run_op(input string name, input logic [2:0] f, input logic [X-1:0] va,
                         input logic [X-1:0] vb, input logic [X-1:0] rh,
                         input logic [X-1:0] rl, input int busy_exp, input logic glitch);
      int n;
      sb_q.push_back({rh, rl});
      n_pushed++;
      exp_hi = rh;
      exp_lo = rl;
      issue(f, va, vb, 1'b0);
      n = 0;
      while (busy && n < 200) begin
         n++;
         start = glitch && (n == 1);
         if (glitch && n == 1) begin
            func = F_MTHI;
            a    = 32'hDEAD_BEEF;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check({name, "_busy_cycles"}, X'(n), X'(busy_exp));
      check({name, "_hi"}, hi, rh);
      check({name, "_lo"}, lo, rl);
   endtask

   initial begin
      int n;
      n_tests  = 0;
      n_fail   = 0;
      n_pushed = 0;
      n_done   = 0;
      rst   = 1'b0;
      start = 1'b0;
      func  = 3'b000;
      a     = '0;
      b     = '0;
      flush = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hi", hi, '0);
      check("reset_lo", lo, '0);
      check("reset_busy", X'(busy), '0);
      check("reset_done", X'(done), '0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      run_op("mult_neg3_7", F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
             MUL_BUSY, 1'b0);
      // Issued in the done cycle of the previous op: back-to-back.
      run_op("div_neg7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
             DIV_BUSY, 1'b0);
      run_op("divu_7_0", F_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, DIV_BUSY, 1'b0);
      run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,
             MUL_BUSY, 1'b1);
      run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
             DIV_BUSY, 1'b0);
      run_op("div_neg5_0", F_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF,
             DIV_BUSY, 1'b0);
      run_op("div_7_neg2", F_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD,
             DIV_BUSY, 1'b0);
      run_op("mult_neg2_neg3", F_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6,
             MUL_BUSY, 1'b0);
      run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_BUSY, 1'b0);

      // MTHI / MTLO take effect after one edge without busy.
      issue(F_MTHI, 32'h0000_1234, 32'd0, 1'b0);
      exp_hi = 32'h0000_1234;
      check("mthi_hi", hi, exp_hi);
      check("mthi_busy", X'(busy), '0);
      issue(F_MTLO, 32'h0000_ABCD, 32'd0, 1'b0);
      exp_lo = 32'h0000_ABCD;
      check("mtlo_lo", lo, exp_lo);

      // Flush mid-divide: no write, no done.
      issue(F_DIVU, 32'd100, 32'd7, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      check("flush_busy_before", X'(busy), X'(1));
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_busy_after", X'(busy), '0);
      repeat (X + 4) @(posedge clk);
      #1;
      check("flush_hi", hi, exp_hi);
      check("flush_lo", lo, exp_lo);

      // flush together with start in IDLE is ignored.
      issue(F_MTLO, 32'h5555_5555, 32'd0, 1'b1);
      check("flush_start_mtlo", lo, exp_lo);
      issue(F_DIV, 32'd9, 32'd3, 1'b1);
      check("flush_start_div_busy", X'(busy), '0);

      // Undefined func is a no-op.
      issue(3'b111, 32'h7777_7777, 32'd1, 1'b0);
      check("undef_busy", X'(busy), '0);
      check("undef_hi", hi, exp_hi);

      // Reset mid-operation clears everything asynchronously.
      issue(F_MULT, 32'd5, 32'd6, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_run_busy", X'(busy), '0);
      check("rst_run_hi", hi, '0);
      check("rst_run_lo", lo, '0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (X + 4) @(posedge clk);
      #1;
      check("post_rst_busy", X'(busy), '0);

      run_op("mult_after_rst", F_MULT, 32'd5, 32'd6, 32'd0, 32'd30, MUL_BUSY, 1'b0);
      n = 0;
      repeat (3) @(posedge clk);
      #1;
      check("done_count", X'(n_done), X'(n_pushed));
      check("queue_empty", X'(sb_q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute bound so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/md_iter_unit.md
# md_iter_unit

Parametrised iterative multiply/divide unit with its own HI/LO architectural registers, for the EX stage of the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from EX and runs multi-cycle operations under a busy/done handshake. The hazard unit stalls the pipeline on `busy`. EX flush aborts an in-flight operation without touching HI/LO.

## Interface
- `XLEN`, 32: operand, HI and LO width; must be even and at least 8.
- `CNT_W`, $clog2(XLEN)+1: iteration counter width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: command valid; sampled only in IDLE.
- `func` in 3: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; other codes are no-ops.
- `a` in XLEN: forwarded rs value (multiplicand/dividend/MT source).
- `b` in XLEN: forwarded rt value (multiplier/divisor).
- `flush` in 1: EX flush; aborts the current or requested operation.
- `busy` out 1: state != IDLE; decoded from the state register, no combinational path from inputs.
- `done` out 1: registered one-cycle pulse when a MUL/DIV result lands in HI/LO.
- `hi` out XLEN: HI register.
- `lo` out XLEN: LO register.

## Operation
- States:
  - IDLE: waits for a command.
  - RUN: performs one iteration per cycle.
  - FIX: applies sign correction and writes HI/LO.
- IDLE with `start` and `flush`=0:
  - MTHI: `hi`<=`a`. MTLO: `lo`<=`a`. Stays in IDLE; `busy` and `done` stay 0.
  - MUL/DIV: latches |a| and |b| (signed ops) or a and b (unsigned ops), plus the result signs. Sets count=0 and moves to RUN.
  - Undefined func: ignored.
- RUN, multiply: shift-add of one multiplier bit per cycle into a 2*XLEN accumulator.
- RUN, divide: restoring, one quotient bit per cycle.
- RUN exit: after XLEN iterations (count==XLEN-1) the next state is FIX.
- FIX:
  - Negate the product if the operand signs differ (signed ops only).
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - Writes `hi`/`lo` and sets `done`=1 for the next cycle, then returns to IDLE.
- Multiply result: `hi`=product[2X-1:X], `lo`=product[X-1:0].
- Divide result: `hi`=remainder, `lo`=quotient.
- Divide by zero, in both signed and unsigned ops: `hi`=a and `lo`=all ones. Full latency still applies; no exception is raised.
- Signed overflow (most-negative / -1): `lo`=most-negative, `hi`=0. Both are natural results of the magnitude datapath.
- `flush` in RUN or FIX: next state is IDLE; HI/LO are not written and `done` stays 0.
- `flush` in IDLE: `start` is ignored that cycle, including MTHI/MTLO.
- `start` while `busy`=1 is ignored. The hazard unit must hold the instruction in EX.
- Reset: state=IDLE, `hi`=0, `lo`=0, `done`=0, count=0. Reset mid-operation discards the operation.

## Timing
- `start` sampled at edge E0 while in IDLE:
  - `busy`=1 from E0 through edge E0+XLEN+1.
  - RUN spans XLEN cycles, FIX spans one cycle.
  - `hi`/`lo` are updated and `done`=1 after edge E0+XLEN+1.
  - `busy`=0 in that same cycle, so total latency is XLEN+1 cycles.
- A new `start` is accepted in the cycle `done`=1 (back-to-back operations are allowed).
- MTHI/MTLO take effect after one edge.
- EX reading `hi`/`lo` (MFHI/MFLO) while `busy`=1 must stall. The hazard unit gates on `busy`; no bypass of the pending result is provided.
- `done` is high for exactly one cycle per completed MUL/DIV.

## Configuration
- `MD_FAST_MUL_EN`:
  - Defined: multiply skips RUN. IDLE goes straight to FIX, which computes a full 2*XLEN product with `*`. Multiply latency is 2 cycles (`busy` high for 1). Divide is unchanged.
  - Undefined: multiply is iterative as described above, with latency XLEN+1.
  - Counter and state encoding are identical in both builds.

## Test plan
- XLEN=32, MULT a=-3 (0xFFFFFFFD), b=7, one-cycle start:
  - `busy` high 33 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, and a single `done` pulse.
  - With `MD_FAST_MUL_EN`: the same values 2 cycles after start.
- DIV a=-7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=7, b=0 → `hi`=7, `lo`=0xFFFFFFFF after 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=1. A second `start` asserted mid-operation is ignored, with no extra `done`.
- Flush and start interactions:
  - MTHI a=0x1234, then DIVU 100/7 with `flush` at cycle 10 → `busy` drops at next edge, `hi`=0x1234, no `done`.
  - `flush`+`start` together in IDLE → nothing happens.
  - Drive `rst` low in RUN → `hi`=`lo`=0 and `busy`=0 immediately.
